// File: rtl/tmds_channel_decoder_pkg.sv
// tmds_channel_decoder_pkg: TMDS control tokens and aligner FSM states shared by the RX channel decoder.
package tmds_channel_decoder_pkg;
  localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    LOCKED = 2'd2
  } state_e;
endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational TMDS symbol decode to control bits or a pixel byte.
module tmds_symbol_decode
  import tmds_channel_decoder_pkg::*;
(
  input  logic [9:0] i_sym,
  output logic       o_is_ctrl,
  output logic       o_c1,
  output logic       o_c0,
  output logic [7:0] o_q
);
  logic [7:0] w_d;
  assign w_d = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];
  assign o_q = {w_d[7:1] ^ w_d[6:0] ^ {7{~i_sym[8]}}, w_d[0]};
  assign o_is_ctrl = i_sym == CTRL_TOK_00 || i_sym == CTRL_TOK_01 ||
                     i_sym == CTRL_TOK_10 || i_sym == CTRL_TOK_11;
  assign {o_c1, o_c0} = i_sym == CTRL_TOK_11 ? 2'b11 :
                        i_sym == CTRL_TOK_10 ? 2'b10 :
                        i_sym == CTRL_TOK_01 ? 2'b01 : 2'b00;
endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: one TMDS RX data channel; barrel-shift word alignment locked on
// control-token runs, then symbol decode to pixel byte or c0/c1.
module tmds_channel_decoder
  import tmds_channel_decoder_pkg::*;
#(
  parameter int CTRL_RUN      = 8,
  parameter int SEARCH_WINDOW = 2048,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic [9:0] I_raw_word,
  output logic [7:0] O_data,
  output logic       O_c0,
  output logic       O_c1,
  output logic       O_de,
  output logic       O_locked,
  output logic [3:0] O_offset
);
  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam int WW = $clog2(SEARCH_WINDOW);
  localparam int TW = $clog2(LOCK_TIMEOUT);
  logic [9:0]    r_raw_d;
  logic [9:0]    r_sym;
  logic [3:0]    r_offset;
  logic [RW-1:0] r_run_cnt;
  logic [WW-1:0] r_win_cnt;
  logic [TW-1:0] r_to_cnt;
  state_e        r_state;
  state_e        w_next;
  logic [19:0]   w_window;
  logic [9:0]    w_sym_next;
  logic          w_is_ctrl;
  logic          w_tc1;
  logic          w_tc0;
  logic [7:0]    w_q;
  logic          w_lk;
  logic          w_de;
  logic          w_c0;
  logic          w_c1;
  logic [7:0]    w_data;
  assign w_window   = {I_raw_word, r_raw_d};
  assign w_sym_next = w_window[{1'b0, r_offset} +: 10];
  assign O_offset   = r_offset;
  tmds_symbol_decode u_dec (
    .i_sym    (r_sym),
    .o_is_ctrl(w_is_ctrl),
    .o_c1     (w_tc1),
    .o_c0     (w_tc0),
    .o_q      (w_q)
  );
  // Counters only run while the FSM stays in their own state, so they never pass their thresholds.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_raw_d   <= '0;
      r_sym     <= '0;
      r_offset  <= '0;
      r_state   <= SEARCH;
      r_run_cnt <= '0;
      r_win_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_raw_d   <= I_raw_word;
      r_sym     <= w_sym_next;
      r_state   <= w_next;
      r_offset  <= r_state == SLIP ? (r_offset == 4'd9 ? 4'd0 : r_offset + 4'd1) : r_offset;
      r_run_cnt <= r_state == SEARCH && w_next == SEARCH && w_is_ctrl ? r_run_cnt + 1'b1 : '0;
      r_win_cnt <= r_state == SEARCH && w_next == SEARCH ? r_win_cnt + 1'b1 : '0;
      r_to_cnt  <= r_state == LOCKED && w_next == LOCKED && !w_is_ctrl ? r_to_cnt + 1'b1 : '0;
    end
  end
  always_comb begin
    w_next = SEARCH;
    if (r_state == SEARCH)
      w_next = w_is_ctrl && r_run_cnt == RW'(CTRL_RUN - 1) ? LOCKED :
               r_win_cnt == WW'(SEARCH_WINDOW - 1) ? SLIP : SEARCH;
    else if (r_state == LOCKED)
      w_next = !w_is_ctrl && r_to_cnt == TW'(LOCK_TIMEOUT - 1) ? SEARCH : LOCKED;
  end
  always_comb begin
    w_lk   = r_state == LOCKED;
    w_de   = w_lk && !w_is_ctrl;
    w_data = w_de ? w_q : 8'd0;
    w_c0   = w_lk ? (w_is_ctrl ? w_tc0 : O_c0) : 1'b0;
    w_c1   = w_lk ? (w_is_ctrl ? w_tc1 : O_c1) : 1'b0;
  end
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_data   <= '0;
      O_c0     <= 1'b0;
      O_c1     <= 1'b0;
      O_de     <= 1'b0;
      O_locked <= 1'b0;
    end else begin
      O_data   <= w_data;
      O_c0     <= w_c0;
      O_c1     <= w_c1;
      O_de     <= w_de;
      O_locked <= w_lk;
    end
  end
endmodule
